pc_ctrl: RTL

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter sequencer (IDLE/FETCH/HOLD); next PC priority is ret > call > load > increment.
// Define PC_CTRL_CALL_STACK_EN to add a 2-entry return-address stack; ports are identical either way.
module pc_ctrl #(
    parameter int                    DATA_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  stall_in,
    input  logic                  fetch_ack_in,
    input  logic                  load_in,
    input  logic                  call_in,
    input  logic                  ret_in,
    input  logic [DATA_WIDTH-1:0] target_in,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] pc_inc_out,
    output logic                  fetch_req_out,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_fetch_req;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_next_pc;

`ifdef PC_CTRL_CALL_STACK_EN
    // Entry 0 is the most recent return address.
    logic [DATA_WIDTH-1:0] r_stk [2];
    logic [1:0]            r_stk_cnt;
`else
    logic                  w_unused_ret;
    assign w_unused_ret = ret_in;
`endif

    assign w_pc_inc = r_pc + 1'b1;

    always_comb begin
        w_next_pc = w_pc_inc;
`ifdef PC_CTRL_CALL_STACK_EN
        if (ret_in) begin
            w_next_pc = (r_stk_cnt == 2'd0) ? RESET_VECTOR : r_stk[0];
        end else if (call_in || load_in) begin
            w_next_pc = target_in;
        end
`else
        if (call_in || load_in) begin
            w_next_pc = target_in;
        end
`endif
    end

    // Handshake: fetch_req_out is valid, fetch_ack_in is ready; the address transfers on a
    // cycle where both are 1, and the PC advances on that edge. A raised stall withdraws valid.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VECTOR;
            r_fetch_req <= 1'b0;
`ifdef PC_CTRL_CALL_STACK_EN
            r_stk[0]    <= '0;
            r_stk[1]    <= '0;
            r_stk_cnt   <= 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= stall_in ? ST_HOLD : ST_FETCH;
                    r_fetch_req <= !stall_in;
                end
                ST_FETCH: begin
                    if (fetch_ack_in) begin
                        r_pc <= w_next_pc;
`ifdef PC_CTRL_CALL_STACK_EN
                        if (ret_in) begin
                            if (r_stk_cnt != 2'd0) begin
                                r_stk[0]  <= r_stk[1];
                                r_stk_cnt <= r_stk_cnt - 2'd1;
                            end
                        end else if (call_in) begin
                            r_stk[1] <= r_stk[0];
                            r_stk[0] <= w_pc_inc;
                            if (r_stk_cnt != 2'd2) begin
                                r_stk_cnt <= r_stk_cnt + 2'd1;
                            end
                        end
`endif
                    end
                    if (stall_in) begin
                        r_state     <= ST_HOLD;
                        r_fetch_req <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_in) begin
                        r_state     <= ST_FETCH;
                        r_fetch_req <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out        = r_pc;
    assign pc_inc_out    = w_pc_inc;
    assign fetch_req_out = r_fetch_req;
    assign state_out     = r_state;

endmodule
